pattern_editor: RTL and testbench
=================================

Name: pattern_editor

Overview:
- Consumes the debounced-level `user_cursor` / `user_edit` codes from the keycode mapper.
- Owns the edit cursor position on a COLS x ROWS pattern grid.
- Performs read-modify-write edits on the pattern cell RAM, which is a synchronous BRAM with 1-cycle read latency.
- Exports the cursor position and a busy flag to the display/highlight logic.

Parameters:
- COLS, 80, grid width in cells; cursor_x range 0..COLS-1.
- ROWS, 30, grid height in cells; cursor_y range 0..ROWS-1.
- DATA_W, 8, width of one pattern cell.
- MAX_VAL, 255, saturation ceiling for increment; must be ≤ 2^DATA_W-1.
- ADDR_W, 12, RAM address width; must be ≥ ceil(log2(COLS*ROWS)).

Ports:
- clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- user_cursor  in  3  000 none | 001 left | 010 right | 011 up | 100 down; level, held while key held.
- user_edit  in  2  00 none | 01 increment | 10 decrement | 11 delete; level.
- mem_addr  out  ADDR_W  cell RAM address.
- mem_rd_en  out  1  RAM read strobe.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_rd_en.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  DATA_W  RAM write data.
- cursor_x  out  7  current column.
- cursor_y  out  5  current row.
- busy  out  1  high while an edit is in flight (state != IDLE).
- edit_done  out  1  one-cycle pulse in the cycle mem_we is asserted.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; cursor (0,0); state IDLE; prev_cursor = prev_edit = 0.
  - Applies mid-edit: mem_we/mem_rd_en go low the cycle after Reset is sampled.
  - The pending write is abandoned; RAM contents are otherwise untouched.
- Event detection: registered copies prev_cursor and prev_edit.
  - Move event = (user_cursor != prev_cursor) && user_cursor != 0.
  - Edit event = (user_edit != prev_edit) && user_edit != 0.
  - Holding a key produces exactly one event.
  - Switching directly between two nonzero codes produces a new event.
  - A key held through Reset fires one event on the first cycle after Reset deasserts.
  - Codes 101-111 on user_cursor are treated as no move.
- Cursor movement (IDLE only; move events while busy are dropped, not queued):
  - Left at x=0 wraps to COLS-1; right at COLS-1 wraps to 0.
  - Up at y=0 wraps to ROWS-1; down at ROWS-1 wraps to 0.
  - cursor_x/cursor_y update the cycle after the event is sampled.
- FSM states: IDLE -> RD -> WAIT -> WR -> IDLE.
  - IDLE: on an edit event sampled at cycle N, latch op and addr = cursor_y*COLS + cursor_x (pre-move value if a move event occurs the same cycle; the move is still applied). Go to RD.
  - RD (N+1): mem_addr = latched addr, mem_rd_en = 1.
  - WAIT (N+2): mem_rdata valid; compute new value and register it into mem_wdata.
  - WR (N+3): mem_we = 1, edit_done = 1, mem_addr = latched addr. Return to IDLE at N+4.
  - busy is high during N+1..N+3. Edit events arriving while busy are dropped.
- Arithmetic:
  - Increment: min(value+1, MAX_VAL); a value already > MAX_VAL is written as MAX_VAL.
  - Decrement: value-1, saturating at 0.
  - Delete: writes 0; still performs the read so timing is uniform.
- mem_rd_en and mem_we are never high in the same cycle. mem_addr is held at its last value when idle.

Test Plan:
- Reset, then hold user_cursor=010 for 5 cycles and release -> cursor_x=1 exactly; second press -> 2.
- From (0,0) press left, then up -> cursor (79,0), then (79,29); at (79,29) press right, then down -> (0,29), then (0,0).
- Cursor (3,2), RAM[163]=0x10, user_edit=01 at cycle N -> mem_rd_en at N+1 with addr 163; mem_we at N+3 with wdata 0x11; edit_done pulses once; busy high N+1..N+3.
- Saturation, each as a separate edit:
  - RAM=0xFF, increment -> writes 0xFF.
  - RAM=0x00, decrement -> writes 0x00.
  - RAM=0x42, delete -> writes 0x00.
- Edit event with a simultaneous right move at (5,0) -> write to addr 5; cursor_x becomes 6. A move pressed during busy is ignored (cursor unchanged after WR).
- Assert Reset during WAIT -> no mem_we ever asserted for that edit; cursor (0,0); busy 0 the next cycle.

Source files
------------

// File: rtl/pattern_editor_if.sv
// Bundles the keycode inputs, the cell RAM port and the display-facing outputs
// of the pattern editor; signal suffixes are named from the editor's point of view.
`timescale 1ns/1ps
interface pattern_editor_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic [2:0]        user_cursor_i;
    logic [1:0]        user_edit_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rd_en_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [6:0]        cursor_x_o;
    logic [4:0]        cursor_y_o;
    logic              busy_o;
    logic              edit_done_o;

    modport slave (
        input  user_cursor_i, user_edit_i, mem_rdata_i,
        output mem_addr_o, mem_rd_en_o, mem_we_o, mem_wdata_o,
        output cursor_x_o, cursor_y_o, busy_o, edit_done_o
    );

    modport master (
        output user_cursor_i, user_edit_i, mem_rdata_i,
        input  mem_addr_o, mem_rd_en_o, mem_we_o, mem_wdata_o,
        input  cursor_x_o, cursor_y_o, busy_o, edit_done_o
    );
endinterface

// File: rtl/pattern_editor.sv
// Cursor owner and read-modify-write cell editor for the pattern grid; key codes
// are levels, so only a change to a nonzero code counts as a press.
`timescale 1ns/1ps
module pattern_editor #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int DATA_W  = 8,
    parameter int MAX_VAL = 255,
    parameter int ADDR_W  = 12
) (
    input  logic             clk,
    input  logic             Reset,
    pattern_editor_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

    state_t            state_q, state_d;
    logic [2:0]        prevCursor_q;
    logic [1:0]        prevEdit_q;
    logic [1:0]        op_q, op_d;
    logic [6:0]        cursorX_q, cursorX_d;
    logic [4:0]        cursorY_q, cursorY_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              moveEvt;
    logic              editEvt;
    logic [ADDR_W-1:0] cursorAddr;
    logic [DATA_W-1:0] newVal;

    assign moveEvt    = (bus.user_cursor_i != prevCursor_q) && (bus.user_cursor_i != 3'd0);
    assign editEvt    = (bus.user_edit_i != prevEdit_q) && (bus.user_edit_i != 2'd0);
    assign cursorAddr = ADDR_W'(cursorY_q) * ADDR_W'(COLS) + ADDR_W'(cursorX_q);

    // Values already above the ceiling clamp down to it rather than growing further.
    always_comb begin
        newVal = '0;
        case (op_q)
            2'b01:   newVal = (bus.mem_rdata_i >= DATA_W'(MAX_VAL)) ? DATA_W'(MAX_VAL)
                                                                     : bus.mem_rdata_i + DATA_W'(1);
            2'b10:   newVal = (bus.mem_rdata_i == '0) ? '0 : bus.mem_rdata_i - DATA_W'(1);
            default: newVal = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            prevCursor_q <= '0;
            prevEdit_q   <= '0;
            op_q         <= '0;
            cursorX_q    <= '0;
            cursorY_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            prevCursor_q <= bus.user_cursor_i;
            prevEdit_q   <= bus.user_edit_i;
            op_q         <= op_d;
            cursorX_q    <= cursorX_d;
            cursorY_q    <= cursorY_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Moves and edits are honoured only in IDLE; an edit latches the pre-move address.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cursorX_d = cursorX_q;
        cursorY_d = cursorY_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (editEvt) begin
                    op_d    = bus.user_edit_i;
                    addr_d  = cursorAddr;
                    state_d = RD;
                end
                if (moveEvt) begin
                    case (bus.user_cursor_i)
                        3'b001:  cursorX_d = (cursorX_q == 7'd0) ? 7'(COLS - 1) : cursorX_q - 7'd1;
                        3'b010:  cursorX_d = (cursorX_q == 7'(COLS - 1)) ? 7'd0 : cursorX_q + 7'd1;
                        3'b011:  cursorY_d = (cursorY_q == 5'd0) ? 5'(ROWS - 1) : cursorY_q - 5'd1;
                        3'b100:  cursorY_d = (cursorY_q == 5'(ROWS - 1)) ? 5'd0 : cursorY_q + 5'd1;
                        default: ;
                    endcase
                end
            end
            RD:   state_d = WAIT;
            WAIT: begin
                wdata_d = newVal;
                state_d = WR;
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_rd_en_o = (state_q == RD);
    assign bus.mem_we_o    = (state_q == WR);
    assign bus.mem_wdata_o = wdata_q;
    assign bus.edit_done_o = (state_q == WR);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.cursor_x_o  = cursorX_q;
    assign bus.cursor_y_o  = cursorY_q;

endmodule

// File: tb/tb_pattern_editor.sv
// Self-checking bench for pattern_editor: directed scenarios plus random key traffic,
// all compared against a cycle-count reference model with its own copy of the grid.
`timescale 1ns/1ps
module tb_pattern_editor;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int MAX_VAL = 255;
    localparam int CELLS   = COLS * ROWS;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    pattern_editor_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    pattern_editor #(.COLS(COLS), .ROWS(ROWS), .DATA_W(8), .MAX_VAL(MAX_VAL), .ADDR_W(12)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Synchronous cell RAM with one-cycle read latency; the bench preloads it through the poke port.
    logic [7:0]  ram [0:4095];
    logic        pokeEn = 1'b0;
    logic [11:0] pokeAddr = '0;
    logic [7:0]  pokeData = '0;
    always @(posedge clk) begin
        if (bus.mem_rd_en_o) bus.mem_rdata_i <= ram[bus.mem_addr_o];
        if (bus.mem_we_o)    ram[bus.mem_addr_o] <= bus.mem_wdata_o;
        if (pokeEn)          ram[pokeAddr] <= pokeData;
    end

    int checks = 0;
    int errors = 0;

    int         mx, my, busyLeft, pendAddr;
    logic [7:0] pendVal;
    logic [2:0] prevC;
    logic [1:0] prevE;
    logic [7:0] expRam [0:4095];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] editResult(input logic [7:0] v, input logic [1:0] op);
        int r;
        case (op)
            2'b01:   r = (int'(v) + 1 > MAX_VAL) ? MAX_VAL : int'(v) + 1;
            2'b10:   r = (v == 8'd0) ? 0 : int'(v) - 1;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    // One clock: drive levels, advance the model across the edge, then compare.
    task automatic applyStimulus(input logic [2:0] cur, input logic [1:0] ed, input logic rst);
        bit mv, ev;
        bus.user_cursor_i = cur;
        bus.user_edit_i   = ed;
        Reset             = rst;
        if (rst) begin
            if (busyLeft == 1) expRam[pendAddr] = pendVal;
            mx = 0; my = 0; busyLeft = 0; prevC = '0; prevE = '0;
        end else begin
            mv = (cur != prevC) && (cur != 3'd0);
            ev = (ed != prevE) && (ed != 2'd0);
            if (busyLeft == 0) begin
                if (ev) begin
                    pendAddr = my * COLS + mx;
                    pendVal  = editResult(expRam[pendAddr], ed);
                    busyLeft = 3;
                end
                if (mv) begin
                    case (cur)
                        3'd1:    mx = (mx + COLS - 1) % COLS;
                        3'd2:    mx = (mx + 1) % COLS;
                        3'd3:    my = (my + ROWS - 1) % ROWS;
                        3'd4:    my = (my + 1) % ROWS;
                        default: ;
                    endcase
                end
            end else begin
                if (busyLeft == 1) expRam[pendAddr] = pendVal;
                busyLeft--;
            end
            prevC = cur;
            prevE = ed;
        end
        @(posedge clk);
        #1;
        pokeEn = 1'b0;
        checkOutput("cursorX", bus.cursor_x_o, mx);
        checkOutput("cursorY", bus.cursor_y_o, my);
        checkOutput("busy", bus.busy_o, busyLeft != 0);
        checkOutput("rdEn", bus.mem_rd_en_o, busyLeft == 3);
        checkOutput("we", bus.mem_we_o, busyLeft == 1);
        checkOutput("editDone", bus.edit_done_o, busyLeft == 1);
        if (busyLeft == 3 || busyLeft == 1) checkOutput("memAddr", bus.mem_addr_o, pendAddr);
        if (busyLeft == 1) checkOutput("wdata", bus.mem_wdata_o, pendVal);
    endtask

    task automatic press(input logic [2:0] c, input logic [1:0] e);
        applyStimulus(c, e, 1'b0);
        applyStimulus(3'd0, 2'd0, 1'b0);
    endtask

    task automatic setCell(input int addr, input logic [7:0] val);
        pokeEn   = 1'b1;
        pokeAddr = 12'(addr);
        pokeData = val;
        expRam[addr] = val;
        applyStimulus(3'd0, 2'd0, 1'b0);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 8 && bus.busy_o; i++) applyStimulus(3'd0, 2'd0, 1'b0);
        checkOutput("idleTimeout", bus.busy_o, 0);
    endtask

    task automatic doEdit(input string tag, input logic [1:0] op, input logic [7:0] expected);
        applyStimulus(3'd0, op, 1'b0);
        applyStimulus(3'd0, 2'd0, 1'b0);
        applyStimulus(3'd0, 2'd0, 1'b0);
        checkOutput({tag, "We"}, bus.mem_we_o, 1);
        checkOutput(tag, bus.mem_wdata_o, expected);
        applyStimulus(3'd0, 2'd0, 1'b0);
    endtask

    initial begin
        logic [2:0] c;
        logic [1:0] e;
        int         hold, mism;
        bit         rst;

        mx = 0; my = 0; busyLeft = 0; pendAddr = 0; pendVal = '0; prevC = '0; prevE = '0;
        bus.user_cursor_i = '0;
        bus.user_edit_i   = '0;
        Reset = 1'b1;

        for (int i = 0; i < CELLS; i++) begin
            pokeEn   = 1'b1;
            pokeAddr = 12'(i);
            pokeData = 8'($urandom_range(0, 255));
            expRam[i] = pokeData;
            @(posedge clk);
            #1;
        end
        pokeEn = 1'b0;

        applyStimulus(3'd0, 2'd0, 1'b1);
        checkOutput("rstAddr", bus.mem_addr_o, 0);
        checkOutput("rstWdata", bus.mem_wdata_o, 0);
        applyStimulus(3'd0, 2'd0, 1'b0);

        repeat (5) applyStimulus(3'd2, 2'd0, 1'b0);
        applyStimulus(3'd0, 2'd0, 1'b0);
        checkOutput("holdRightOnce", bus.cursor_x_o, 1);
        press(3'd2, 2'd0);
        checkOutput("secondRight", bus.cursor_x_o, 2);

        applyStimulus(3'd0, 2'd0, 1'b1);
        press(3'd1, 2'd0);
        checkOutput("wrapLeftX", bus.cursor_x_o, 79);
        press(3'd3, 2'd0);
        checkOutput("wrapUpY", bus.cursor_y_o, 29);
        press(3'd2, 2'd0);
        checkOutput("wrapRightX", bus.cursor_x_o, 0);
        press(3'd4, 2'd0);
        checkOutput("wrapDownY", bus.cursor_y_o, 0);

        repeat (3) press(3'd2, 2'd0);
        repeat (2) press(3'd4, 2'd0);
        setCell(163, 8'h10);
        applyStimulus(3'd0, 2'd1, 1'b0);
        checkOutput("rdEn163", bus.mem_rd_en_o, 1);
        checkOutput("rdAddr163", bus.mem_addr_o, 163);
        applyStimulus(3'd0, 2'd1, 1'b0);
        checkOutput("busyWait", bus.busy_o, 1);
        applyStimulus(3'd0, 2'd0, 1'b0);
        checkOutput("wrAddr163", bus.mem_addr_o, 163);
        checkOutput("wdata11", bus.mem_wdata_o, 8'h11);
        checkOutput("doneWr", bus.edit_done_o, 1);
        applyStimulus(3'd0, 2'd0, 1'b0);
        checkOutput("doneOnce", bus.edit_done_o, 0);
        checkOutput("ram163", ram[163], 8'h11);

        setCell(163, 8'hFF);
        doEdit("incSat", 2'd1, 8'hFF);
        setCell(163, 8'h00);
        doEdit("decSat", 2'd2, 8'h00);
        setCell(163, 8'h42);
        doEdit("delete", 2'd3, 8'h00);

        applyStimulus(3'd0, 2'd0, 1'b1);
        repeat (5) press(3'd2, 2'd0);
        applyStimulus(3'd2, 2'd1, 1'b0);
        checkOutput("simulAddr", bus.mem_addr_o, 5);
        checkOutput("simulX", bus.cursor_x_o, 6);
        applyStimulus(3'd1, 2'd0, 1'b0);
        applyStimulus(3'd0, 2'd0, 1'b0);
        checkOutput("simulWrAddr", bus.mem_addr_o, 5);
        applyStimulus(3'd0, 2'd0, 1'b0);
        checkOutput("busyMoveDropped", bus.cursor_x_o, 6);

        setCell(6, 8'h33);
        applyStimulus(3'd0, 2'd1, 1'b0);
        applyStimulus(3'd0, 2'd0, 1'b0);
        applyStimulus(3'd0, 2'd0, 1'b1);
        checkOutput("abortBusy", bus.busy_o, 0);
        checkOutput("abortX", bus.cursor_x_o, 0);
        repeat (4) applyStimulus(3'd0, 2'd0, 1'b0);
        checkOutput("abortRamKept", ram[6], 8'h33);

        applyStimulus(3'd2, 2'd0, 1'b1);
        applyStimulus(3'd2, 2'd0, 1'b0);
        checkOutput("heldThroughReset", bus.cursor_x_o, 1);

        repeat (200) begin
            c    = 3'($urandom_range(0, 7));
            e    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            hold = $urandom_range(1, 4);
            rst  = ($urandom_range(0, 39) == 0);
            applyStimulus(c, e, rst);
            for (int k = 1; k < hold; k++) applyStimulus(c, e, 1'b0);
        end
        applyStimulus(3'd0, 2'd0, 1'b0);
        waitIdle();

        mism = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== expRam[i]) mism++;
        checkOutput("ramImage", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
